// File: rtl/cmul_seq.sv
// rtl/cmul_seq.sv - sequential sign-magnitude complex multiplier (one shared real multiplier over 4 cycles)

module cmul_smag_mul #(
    parameter int N = 8,
    parameter int Q = 6
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] p,
    output logic         ovr
);
    logic [2*N-3:0] full;
    logic [2*N-3:0] shifted;
    logic [N-2:0]   mag;

    // Magnitude is truncated toward zero; an out-of-range result keeps only its low bits.
    assign full    = {{(N-1){1'b0}}, a[N-2:0]} * {{(N-1){1'b0}}, b[N-2:0]};
    assign shifted = full >> Q;
    assign ovr     = |shifted[2*N-3:N-1];
    assign mag     = shifted[N-2:0];
    assign p       = {(a[N-1] ^ b[N-1]) && (mag != '0), mag};
endmodule

module cmul_seq #(
    parameter int N = 8,
    parameter int Q = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_ar,
    input  logic [N-1:0] i_ai,
    input  logic [N-1:0] i_br,
    input  logic [N-1:0] i_bi,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_pr,
    output logic [N-1:0] o_pi,
    output logic         o_ovr
);
    localparam int W = N + 2;
    localparam logic [W-1:0] MAX_MAG = W'((1 << (N - 1)) - 1);

    typedef enum logic [1:0] {IDLE, MUL, ADD, OUT} state_t;

    state_t       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [N-1:0] ar_q, ar_d, ai_q, ai_d, br_q, br_d, bi_q, bi_d;
    logic [N-1:0] p_q [4];
    logic [N-1:0] p_d [4];
    logic         ovr_acc_q, ovr_acc_d;
    logic         o_valid_q, o_valid_d;
    logic [N-1:0] o_pr_q, o_pr_d, o_pi_q, o_pi_d;
    logic         o_ovr_q, o_ovr_d;

    logic [N-1:0] mul_a, mul_b, mul_p;
    logic         mul_ovr;
    logic signed [W-1:0] re_sum, im_sum;
    logic [N:0]   re_sm, im_sm;

    function automatic logic signed [W-1:0] to_tc(input logic [N-1:0] v);
        logic signed [W-1:0] m;
        m = signed'({{(W-N+1){1'b0}}, v[N-2:0]});
        return v[N-1] ? -m : m;
    endfunction

    // Returns {saturated, sign, magnitude}; a zero sum is never negative so -0 cannot appear.
    function automatic logic [N:0] to_sm(input logic signed [W-1:0] s);
        logic [W-1:0] mag;
        logic         sat;
        logic [N-2:0] m;
        mag = s[W-1] ? -s : s;
        sat = (mag > MAX_MAG);
        m   = sat ? MAX_MAG[N-2:0] : mag[N-2:0];
        return {sat, s[W-1], m};
    endfunction

    always_comb begin
        mul_a = ar_q;
        mul_b = br_q;
        case (cnt_q)
            2'd0: begin mul_a = ar_q; mul_b = br_q; end
            2'd1: begin mul_a = ai_q; mul_b = bi_q; end
            2'd2: begin mul_a = ar_q; mul_b = bi_q; end
            default: begin mul_a = ai_q; mul_b = br_q; end
        endcase
    end

    cmul_smag_mul #(.N(N), .Q(Q)) u_mul (
        .a   (mul_a),
        .b   (mul_b),
        .p   (mul_p),
        .ovr (mul_ovr)
    );

    assign re_sum = to_tc(p_q[0]) - to_tc(p_q[1]);
    assign im_sum = to_tc(p_q[3]) + to_tc(p_q[2]);
    assign re_sm  = to_sm(re_sum);
    assign im_sm  = to_sm(im_sum);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ar_d      = ar_q;
        ai_d      = ai_q;
        br_d      = br_q;
        bi_d      = bi_q;
        p_d       = p_q;
        ovr_acc_d = ovr_acc_q;
        o_valid_d = o_valid_q;
        o_pr_d    = o_pr_q;
        o_pi_d    = o_pi_q;
        o_ovr_d   = o_ovr_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    ar_d      = i_ar;
                    ai_d      = i_ai;
                    br_d      = i_br;
                    bi_d      = i_bi;
                    ovr_acc_d = 1'b0;
                    cnt_d     = 2'd0;
                    state_d   = MUL;
                end
            end
            MUL: begin
                p_d[cnt_q] = mul_p;
                ovr_acc_d  = ovr_acc_q | mul_ovr;
                cnt_d      = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = ADD;
            end
            ADD: begin
                o_pr_d    = re_sm[N-1:0];
                o_pi_d    = im_sm[N-1:0];
                o_ovr_d   = ovr_acc_q | re_sm[N] | im_sm[N];
                o_valid_d = 1'b1;
                state_d   = OUT;
            end
            default: begin
                if (i_ready) begin
                    o_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            ar_q      <= '0;
            ai_q      <= '0;
            br_q      <= '0;
            bi_q      <= '0;
            for (int i = 0; i < 4; i++) p_q[i] <= '0;
            ovr_acc_q <= 1'b0;
            o_valid_q <= 1'b0;
            o_pr_q    <= '0;
            o_pi_q    <= '0;
            o_ovr_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ar_q      <= ar_d;
            ai_q      <= ai_d;
            br_q      <= br_d;
            bi_q      <= bi_d;
            p_q       <= p_d;
            ovr_acc_q <= ovr_acc_d;
            o_valid_q <= o_valid_d;
            o_pr_q    <= o_pr_d;
            o_pi_q    <= o_pi_d;
            o_ovr_q   <= o_ovr_d;
        end
    end

    assign o_ready = (state_q == IDLE);
    assign o_valid = o_valid_q;
    assign o_pr    = o_pr_q;
    assign o_pi    = o_pi_q;
    assign o_ovr   = o_ovr_q;
endmodule

// File: tb/tb_cmul_seq.sv
// tb/tb_cmul_seq.sv - scoreboard bench for cmul_seq with directed vectors

module tb_cmul_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_valid = 1'b0;
    logic       o_ready;
    logic [7:0] i_ar = '0, i_ai = '0, i_br = '0, i_bi = '0;
    logic       o_valid;
    logic       i_ready = 1'b1;
    logic [7:0] o_pr, o_pi;
    logic       o_ovr;

    typedef struct {
        logic [7:0] pr;
        logic [7:0] pi;
        logic       ovr;
        int         acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic prev_valid = 1'b0;

    cmul_seq #(.N(8), .Q(6)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_ar    (i_ar),
        .i_ai    (i_ai),
        .i_br    (i_br),
        .i_bi    (i_bi),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_pr    (o_pr),
        .o_pi    (o_pi),
        .o_ovr   (o_ovr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: latency check on o_valid rise, value check on each handshake.
    always @(negedge clk) begin
        if (rst_n && o_valid && !prev_valid) begin
            if (exp_q.size() == 0) check("spurious_valid", 1, 0);
            else check("latency", cyc, exp_q[0].acc_cyc + 5);
        end
        if (rst_n && o_valid && i_ready && exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("o_pr", int'(o_pr), int'(e.pr));
            check("o_pi", int'(o_pi), int'(e.pi));
            check("o_ovr", int'(o_ovr), int'(e.ovr));
        end
        prev_valid = o_valid;
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [7:0] ar, ai, br, bi,
                        input logic [7:0] epr, epi, input logic eovr, input bit push);
        int t;
        exp_t e;
        t = 0;
        while (!o_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!o_ready) check("ready_timeout", 0, 1);
        i_valid = 1'b1;
        i_ar = ar; i_ai = ai; i_br = br; i_bi = bi;
        @(posedge clk); #1;
        i_valid = 1'b0;
        if (push) begin
            e.pr = epr; e.pi = epi; e.ovr = eovr; e.acc_cyc = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_valid();
        int t;
        t = 0;
        while (!o_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!o_valid) check("valid_timeout", 0, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_o_valid", int'(o_valid), 0);
        check("rst_o_ready", int'(o_ready), 1);
        check("rst_o_pr", int'(o_pr), 0);
        check("rst_o_pi", int'(o_pi), 0);
        check("rst_o_ovr", int'(o_ovr), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(8'h20, 8'h20, 8'h20, 8'hA0, 8'h20, 8'h00, 1'b0, 1'b1);
        send(8'h40, 8'h40, 8'h40, 8'h40, 8'h00, 8'h7F, 1'b1, 1'b1);
        send(8'h60, 8'h00, 8'h60, 8'h00, 8'h10, 8'h00, 1'b1, 1'b1);
        send(8'h80, 8'h80, 8'h40, 8'h40, 8'h00, 8'h00, 1'b0, 1'b1);
        send(8'hC0, 8'h20, 8'h40, 8'h40, 8'hE0, 8'hA0, 1'b0, 1'b1);
        send(8'h30, 8'h10, 8'h08, 8'h88, 8'h08, 8'h84, 1'b0, 1'b1);
        send(8'h7F, 8'h7F, 8'h7F, 8'hFF, 8'h7F, 8'h00, 1'b1, 1'b1);
        send(8'hFF, 8'h7F, 8'h7F, 8'h7F, 8'hFF, 8'h00, 1'b1, 1'b1);

        // Backpressure: hold OUT for 10 cycles while offering another operand set.
        wait_valid();
        @(posedge clk); #1;
        i_ready = 1'b0;
        send(8'h40, 8'h40, 8'h40, 8'h40, 8'h00, 8'h7F, 1'b1, 1'b1);
        wait_valid();
        i_valid = 1'b1;
        i_ar = 8'h20; i_ai = 8'h20; i_br = 8'h20; i_bi = 8'hA0;
        for (int i = 0; i < 10; i++) begin
            check("hold_valid", int'(o_valid), 1);
            check("hold_ready", int'(o_ready), 0);
            check("hold_pr", int'(o_pr), 8'h00);
            check("hold_pi", int'(o_pi), 8'h7F);
            check("hold_ovr", int'(o_ovr), 1);
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge clk); #1;
        check("release_valid", int'(o_valid), 0);
        check("release_ready", int'(o_ready), 1);

        // Reset during MUL with cnt==2 drops the transaction.
        send(8'h40, 8'h40, 8'h40, 8'h40, 8'h00, 8'h7F, 1'b1, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_valid", int'(o_valid), 0);
        check("midrst_ready", int'(o_ready), 1);
        check("midrst_pr", int'(o_pr), 0);
        check("midrst_pi", int'(o_pi), 0);
        check("midrst_ovr", int'(o_ovr), 0);
        repeat (8) @(posedge clk);
        #1;
        check("midrst_no_valid", int'(o_valid), 0);
        send(8'h20, 8'h20, 8'h20, 8'hA0, 8'h20, 8'h00, 1'b0, 1'b1);

        for (int t = 0; t < 100 && exp_q.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
